// File: rtl/ex_mul_unit.sv
// EX-stage iterative shift-add multiplier: one multiplier bit per cycle, early exit
// once the remaining multiplier bits are zero, stall upstream while iterating.
module ex_mul_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned CNT_BITS = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EX_mul,
  input  logic [XLEN-1:0] EX_a,
  input  logic [XLEN-1:0] EX_b,
  input  logic [4:0]      EX_rd,
  input  logic            EX_we,
  input  logic            EX_taken,
  input  logic            MEM_stall,
  output logic            MUL_stall,
  output logic            MUL_valid,
  output logic [XLEN-1:0] MUL_result,
  output logic [4:0]      MUL_rd,
  output logic            MUL_we
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nxt;
  logic [XLEN-1:0]     mcand, mplier, acc;
  logic [CNT_BITS-1:0] cnt;
  logic [4:0]          rd_q;
  logic                we_q;
  logic                start, iterate, last_iter;

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    iterate    = 1'b0;
    MUL_stall  = 1'b0;
    MUL_valid  = 1'b0;
    MUL_result = '0;
    MUL_rd     = '0;
    MUL_we     = 1'b0;
    // Stop as soon as no set multiplier bits remain after this step.
    last_iter  = ((mplier >> 1) == '0) || (cnt == CNT_BITS'(XLEN - 1));
    case (state)
      IDLE: begin
        if (EX_mul && !EX_taken) begin
          start     = 1'b1;
          MUL_stall = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        MUL_stall = 1'b1;
        if (EX_taken) begin
          state_nxt = IDLE;
        end else begin
          iterate = 1'b1;
          if (last_iter) state_nxt = DONE;
        end
      end
      DONE: begin
        MUL_valid  = 1'b1;
        MUL_result = acc;
        MUL_rd     = rd_q;
        MUL_we     = we_q;
        if (!MEM_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      rd_q   <= '0;
      we_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        mcand  <= EX_a;
        mplier <= EX_b;
        acc    <= '0;
        cnt    <= '0;
        rd_q   <= EX_rd;
        we_q   <= EX_we;
      end else if (iterate) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed bench for ex_mul_unit: stimulus pushes expected results into a queue,
// an independent monitor checks every cycle MUL_valid is presented.
module tb_ex_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_mul;
  logic [31:0] EX_a, EX_b;
  logic [4:0]  EX_rd;
  logic        EX_we;
  logic        EX_taken;
  logic        MEM_stall;
  logic        MUL_stall, MUL_valid, MUL_we;
  logic [31:0] MUL_result;
  logic [4:0]  MUL_rd;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  ex_mul_unit #(.XLEN(32), .CNT_BITS(6)) dut (
    .clk(clk), .rst(rst), .EX_mul(EX_mul), .EX_a(EX_a), .EX_b(EX_b),
    .EX_rd(EX_rd), .EX_we(EX_we), .EX_taken(EX_taken), .MEM_stall(MEM_stall),
    .MUL_stall(MUL_stall), .MUL_valid(MUL_valid), .MUL_result(MUL_result),
    .MUL_rd(MUL_rd), .MUL_we(MUL_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples after stimulus has settled; pops only when the result transfers.
  always begin
    @(negedge clk);
    #2;
    if (rst && MUL_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", {63'd0, MUL_valid}, 64'd0);
      end else begin
        check("result", {32'd0, MUL_result}, {32'd0, q[0].res});
        check("rd", {59'd0, MUL_rd}, {59'd0, q[0].rd});
        check("we", {63'd0, MUL_we}, {63'd0, q[0].we});
        if (!MEM_stall) void'(q.pop_front());
      end
    end
  end

  // Called just after a negedge; returns just after the negedge of the first IDLE cycle.
  task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic we, input logic [31:0] exp_res, input int exp_busy,
                        input int hold, input logic last);
    int busy;
    EX_a = a; EX_b = b; EX_rd = rd; EX_we = we; EX_mul = 1'b1; EX_taken = 1'b0;
    q.push_back('{res: exp_res, rd: rd, we: we});
    #1 check("accept_stall", {63'd0, MUL_stall}, 64'd1);
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (MUL_valid || !MUL_stall) break;
      busy++;
    end
    MEM_stall = (hold > 0);
    if (last) EX_mul = 1'b0;
    check("busy_cycles", busy, exp_busy);
    check("done_valid", {63'd0, MUL_valid}, 64'd1);
    check("done_stall", {63'd0, MUL_stall}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, MUL_valid}, 64'd1);
      if (i == hold - 1) MEM_stall = 1'b0;
    end
    @(negedge clk);
    check("after_done_valid", {63'd0, MUL_valid}, 64'd0);
    if (last) check("after_done_stall", {63'd0, MUL_stall}, 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_stall"}, {63'd0, MUL_stall}, 64'd0);
    check({tag, "_valid"}, {63'd0, MUL_valid}, 64'd0);
    check({tag, "_result"}, {32'd0, MUL_result}, 64'd0);
    check({tag, "_rd"}, {59'd0, MUL_rd}, 64'd0);
    check({tag, "_we"}, {63'd0, MUL_we}, 64'd0);
  endtask

  initial begin
    rst = 1'b0; EX_mul = 1'b0; EX_a = '0; EX_b = '0; EX_rd = '0; EX_we = 1'b0;
    EX_taken = 1'b0; MEM_stall = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    mul_op(32'd6, 32'd7, 5'd5, 1'b1, 32'd42, 3, 0, 1'b1);
    mul_op(32'h1234, 32'd0, 5'd7, 1'b1, 32'd0, 1, 0, 1'b1);
    mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001, 32, 0, 1'b1);
    mul_op(32'hFFFF_FFFD, 32'd5, 5'd10, 1'b1, 32'hFFFF_FFF1, 3, 0, 1'b1);
    mul_op(32'd9, 32'd3, 5'd12, 1'b1, 32'd27, 2, 3, 1'b1);

    // Flush in the 4th BUSY cycle of 100*0x80.
    EX_a = 32'd100; EX_b = 32'h80; EX_rd = 5'd3; EX_we = 1'b1; EX_mul = 1'b1;
    repeat (4) @(negedge clk);
    check("flush_busy_stall", {63'd0, MUL_stall}, 64'd1);
    EX_taken = 1'b1; EX_mul = 1'b0;
    @(negedge clk);
    EX_taken = 1'b0;
    check("flush_stall", {63'd0, MUL_stall}, 64'd0);
    check("flush_valid", {63'd0, MUL_valid}, 64'd0);
    repeat (10) @(negedge clk);
    check("flush_late_valid", {63'd0, MUL_valid}, 64'd0);

    // Reset while BUSY.
    EX_a = 32'd100; EX_b = 32'h80; EX_rd = 5'd9; EX_we = 1'b1; EX_mul = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; EX_mul = 1'b0;
    @(negedge clk);
    check_zero_outputs("midreset");
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("postreset");
    mul_op(32'd2, 32'd3, 5'd4, 1'b1, 32'd6, 2, 0, 1'b1);

    // Back-to-back with EX_mul held high.
    mul_op(32'd3, 32'd4, 5'd1, 1'b1, 32'd12, 3, 0, 1'b0);
    mul_op(32'd5, 32'd5, 5'd2, 1'b1, 32'd25, 3, 0, 1'b1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/ex_mul_unit.md
Name: ex_mul_unit

Overview:
- Iterative shift-add multiplier in the EX stage.
- Consumes the operands and control flopped out of the decode-to-execute pipeline register when the EX multiply flag is set.
- Produces the low XLEN bits of the product together with destination/write-enable for the EX-to-MEM boundary.
- Raises a stall while iterating so that the decode-to-execute register and the upstream stages hold.

Parameters:
- XLEN, 32, operand and result width.
- CNT_BITS, 6, iteration counter width; must satisfy 2^CNT_BITS > XLEN.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- EX_mul  input  1  multiply instruction present in EX.
- EX_a  input  XLEN  multiplicand.
- EX_b  input  XLEN  multiplier.
- EX_rd  input  5  destination register.
- EX_we  input  1  register write enable of the EX instruction.
- EX_taken  input  1  branch-taken flush; aborts any multiply in progress.
- MEM_stall  input  1  downstream hold; result must be kept stable while high.
- MUL_stall  output  1  hold request to decode-to-execute register and earlier stages.
- MUL_valid  output  1  result valid for the EX-to-MEM register.
- MUL_result  output  XLEN  low XLEN bits of EX_a*EX_b.
- MUL_rd  output  5  latched destination register.
- MUL_we  output  1  latched write enable, qualified by MUL_valid.

Behaviour:
- States: IDLE, BUSY, DONE. Internal registers: mcand (XLEN), mplier (XLEN), acc (XLEN), cnt (CNT_BITS), rd_q, we_q.
- Reset (rst==0 at an edge): state=IDLE; acc, mcand, mplier, cnt, rd_q and we_q are cleared. Outputs after reset: MUL_stall=0, MUL_valid=0, MUL_result=0, MUL_rd=0, MUL_we=0. Reset overrides every other input, including mid-BUSY and mid-DONE.
- IDLE:
  - If EX_mul=1 and EX_taken=0: latch mcand=EX_a, mplier=EX_b, acc=0, cnt=0, rd_q=EX_rd, we_q=EX_we; go to BUSY.
  - MUL_stall is combinationally 1 in this cycle (EX_mul & ~EX_taken in IDLE), so the EX instruction is held.
  - EX_mul=0 or EX_taken=1: stay in IDLE.
- BUSY, one iteration per cycle:
  - If mplier[0]=1, acc <= acc + mcand (mod 2^XLEN).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - Go to DONE when (mplier >> 1)==0 or cnt==XLEN-1; otherwise remain in BUSY.
  - Busy cycles = max(1, msb_index(EX_b)+1); for example, b=0 gives 1 cycle and b=0xFFFFFFFF gives 32 cycles.
  - MUL_stall=1 throughout BUSY.
  - EX_taken=1 in BUSY: go to IDLE; no MUL_valid; acc is discarded.
  - MEM_stall has no effect in BUSY; iteration continues.
- DONE:
  - MUL_valid=1, MUL_result=acc, MUL_rd=rd_q, MUL_we=we_q. MUL_stall=0.
  - If MEM_stall=1: remain in DONE with all outputs held stable.
  - If MEM_stall=0: go to IDLE at the edge. The pipeline advances at that same edge, so the multiply instruction leaves EX and is not restarted.
  - EX_taken in DONE does not cancel the result, because the multiply is older than the branch.
- Outside DONE: MUL_valid=0, MUL_we=0, MUL_result=0, MUL_rd=0.
- Total latency from EX entry to MUL_valid = busy cycles + 1.
- Back-to-back multiplies: the next EX_mul is accepted in the first IDLE cycle after DONE; there are no bubbles beyond the IDLE acceptance cycle.
- Product is unsigned shift-add truncated to XLEN bits, which is identical for signed operands in two's complement.

Test Plan:
- Basic: EX_a=6, EX_b=7, EX_rd=5, EX_we=1 → 3 BUSY cycles with MUL_stall=1, then MUL_valid=1, MUL_result=42, MUL_rd=5, MUL_we=1 for one cycle, then IDLE.
- Boundaries:
  - a=0x1234, b=0 → 1 BUSY cycle, result 0.
  - a=b=0xFFFFFFFF → 32 BUSY cycles, result 0x00000001.
  - a=0xFFFFFFFD (−3), b=5 → result 0xFFFFFFF1.
- Downstream hold: a=9, b=3; hold MEM_stall=1 for 3 cycles on entry to DONE → MUL_valid and result 27 stay stable for 4 cycles, then IDLE.
- Flush: a=100, b=0x80 (8 BUSY cycles); assert EX_taken in the 4th BUSY cycle → next cycle IDLE, MUL_valid never asserts, MUL_stall=0.
- Reset mid-operation: drive rst=0 during BUSY → next edge all outputs are 0 and state is IDLE. After releasing rst, a=2, b=3 → result 6.
- Back-to-back: 3*4 then 5*5 with EX_mul held → results 12 and 25, each with one MUL_valid pulse, in order.
